rx_fifo_sync: RTL and testbench

Clocked, parametrised receive FIFO for the UART datapath, buffering received characters between the receiver and the host/bus read side. It generalises the combinational receive FIFO into a single-clock design with programmable depth and almost-full threshold, simultaneous push/pop, an occupancy count, sticky overflow and underflow flags, and a BIST freeze. Optionally, it supports first-word-fall-through reads.

---
 rtl/rx_fifo_pkg.sv | 19 +
 rtl/rx_fifo_ram.sv | 23 ++
 rtl/rx_fifo_sync.sv | 103 ++++++++++
 tb/tb_rx_fifo_sync.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rx_fifo_pkg.sv
// Shared constants, count-width helper and flag bundle for the UART receive FIFO.
package rx_fifo_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int FIFO_WIDTH_DEF = 4;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int cnt_w(input int fifo_width);
        return fifo_width + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

endpackage

// File: rtl/rx_fifo_ram.sv
// DEPTH x DATA_BITS storage: synchronous write, asynchronous read.
module rx_fifo_ram #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read returns pre-write contents when raddr == waddr in the write cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo_sync.sv
// Single-clock UART receive FIFO with count, sticky flags and BIST freeze.
// Define RX_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module rx_fifo_sync
    import rx_fifo_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int FIFO_WIDTH  = FIFO_WIDTH_DEF,
    parameter int FULL_THRESH = 2**FIFO_WIDTH/2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] Rx_Data,
    input  logic                 Data_Rdy,
    input  logic                 Pop_Data,
    input  logic                 Clr_Flags,
    input  logic                 BIST_Mode,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow,
    output logic                 FIFO_Underflow,
    output logic [FIFO_WIDTH:0]  FIFO_Count,
    output logic                 Data_Valid,
    output logic [DATA_BITS-1:0] Data_Out
);

    localparam int CW = cnt_w(FIFO_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(2**FIFO_WIDTH);
    localparam logic [CW-1:0] THRESH_C = CW'(FULL_THRESH);

    logic [FIFO_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_nxt;
    fifo_flags_t           flags_q;
    logic [DATA_BITS-1:0]  dout_q, rd_data;
    logic                  push_acc, pop_acc, ovf_evt, udf_evt;

    // A pop from a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        pop_acc   = Pop_Data && !BIST_Mode && (count != '0);
        push_acc  = Data_Rdy && !BIST_Mode && ((count != DEPTH_C) || pop_acc);
        ovf_evt   = Data_Rdy && (count == DEPTH_C) && !pop_acc;
        udf_evt   = Pop_Data && (count == '0);
        count_nxt = count + CW'(push_acc) - CW'(pop_acc);
    end

    rx_fifo_ram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_W    (FIFO_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (Rx_Data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

`ifndef RX_FIFO_FWFT_EN
    logic dv_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            flags_q <= '{empty: 1'b1, full: 1'b0, overflow: 1'b0, underflow: 1'b0};
            dout_q  <= '0;
`ifndef RX_FIFO_FWFT_EN
            dv_q    <= 1'b0;
`endif
        end else if (!BIST_Mode) begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= rd_data;
            end
            count             <= count_nxt;
            flags_q.empty     <= (count_nxt == '0);
            flags_q.full      <= (count_nxt >= THRESH_C);
            flags_q.overflow  <= ovf_evt || (flags_q.overflow && !Clr_Flags);
            flags_q.underflow <= udf_evt || (flags_q.underflow && !Clr_Flags);
`ifndef RX_FIFO_FWFT_EN
            dv_q              <= pop_acc;
`endif
        end
    end

    assign FIFO_Empty     = flags_q.empty;
    assign FIFO_Full      = flags_q.full;
    assign FIFO_Overflow  = flags_q.overflow;
    assign FIFO_Underflow = flags_q.underflow;
    assign FIFO_Count     = count;

`ifdef RX_FIFO_FWFT_EN
    // dout_q keeps the last acknowledged word on show while the FIFO is empty.
    assign Data_Out   = flags_q.empty ? dout_q : rd_data;
    assign Data_Valid = !flags_q.empty && !BIST_Mode;
`else
    assign Data_Out   = dout_q;
    assign Data_Valid = dv_q && !BIST_Mode;
`endif

endmodule

// File: tb/tb_rx_fifo_sync.sv
// Directed bench for rx_fifo_sync: hand-computed vector table plus queue-model sequences.
module tb_rx_fifo_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Rx_Data = '0;
    logic       Data_Rdy = 1'b0, Pop_Data = 1'b0, Clr_Flags = 1'b0, BIST_Mode = 1'b0;
    logic       FIFO_Empty, FIFO_Full, FIFO_Overflow, FIFO_Underflow, Data_Valid;
    logic [4:0] FIFO_Count;
    logic [7:0] Data_Out;

`ifdef RX_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    rx_fifo_sync dut (
        .clk(clk), .rst_n(rst_n), .Rx_Data(Rx_Data), .Data_Rdy(Data_Rdy),
        .Pop_Data(Pop_Data), .Clr_Flags(Clr_Flags), .BIST_Mode(BIST_Mode),
        .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full), .FIFO_Overflow(FIFO_Overflow),
        .FIFO_Underflow(FIFO_Underflow), .FIFO_Count(FIFO_Count),
        .Data_Valid(Data_Valid), .Data_Out(Data_Out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic pop, input logic [7:0] d,
                         input logic clr, input logic bist);
        Data_Rdy = rdy; Pop_Data = pop; Rx_Data = d; Clr_Flags = clr; BIST_Mode = bist;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rdy, pop, clr, bist;
        logic [7:0] d;
        logic [4:0] cnt;
        logic       emp, ful, ovf, udf, dv;
        logic [7:0] dout;
    } vec_t;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf, m_udf, m_dv;
    logic [7:0] m_last;

    task automatic check_model(input string tag);
        logic [7:0] exp_out;
        logic       exp_dv;
        exp_out = (FWFT && q.size() > 0) ? q[0] : m_last;
        exp_dv  = FWFT ? (q.size() > 0 && !BIST_Mode) : (m_dv && !BIST_Mode);
        chk({tag, " count"}, FIFO_Count, q.size());
        chk({tag, " empty"}, FIFO_Empty, q.size() == 0);
        chk({tag, " full"}, FIFO_Full, q.size() >= 8);
        chk({tag, " ovf"}, FIFO_Overflow, m_ovf);
        chk({tag, " udf"}, FIFO_Underflow, m_udf);
        chk({tag, " dv"}, Data_Valid, exp_dv);
        chk({tag, " dout"}, Data_Out, exp_out);
    endtask

    task automatic mstep(input string tag, input logic rdy, input logic pop,
                         input logic [7:0] d, input logic clr, input logic bist);
        bit pa, pu, ove, ude;
        drive(rdy, pop, d, clr, bist);
        if (!bist) begin
            pa  = pop && q.size() > 0;
            pu  = rdy && (q.size() < 16 || pa);
            ove = rdy && q.size() == 16 && !pa;
            ude = pop && q.size() == 0;
            if (pa) m_last = q.pop_front();
            if (pu) q.push_back(d);
            m_ovf = ove || (m_ovf && !clr);
            m_udf = ude || (m_udf && !clr);
            m_dv  = pa;
        end
        check_model(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_dv = 0; m_last = 8'h00;
    endtask

    initial begin
        vec_t tbl[13];
        //            rdy pop clr bist  d      cnt emp ful ovf udf dv dout
        tbl[0]  = '{1, 0, 0, 0, 8'h11, 5'd1, 0, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 0, 0, 0, 8'h22, 5'd2, 0, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{0, 1, 0, 0, 8'h00, 5'd1, 0, 0, 0, 0, 1, 8'h11};
        tbl[3]  = '{0, 0, 0, 0, 8'h00, 5'd1, 0, 0, 0, 0, 0, 8'h11};
        tbl[4]  = '{1, 1, 0, 0, 8'h33, 5'd1, 0, 0, 0, 0, 1, 8'h22};
        tbl[5]  = '{0, 1, 0, 0, 8'h00, 5'd0, 1, 0, 0, 0, 1, 8'h33};
        tbl[6]  = '{0, 1, 0, 0, 8'h00, 5'd0, 1, 0, 0, 1, 0, 8'h33};
        tbl[7]  = '{0, 0, 1, 0, 8'h00, 5'd0, 1, 0, 0, 0, 0, 8'h33};
        tbl[8]  = '{1, 1, 0, 0, 8'h44, 5'd1, 0, 0, 0, 1, 0, 8'h33};
        tbl[9]  = '{1, 1, 1, 1, 8'h55, 5'd1, 0, 0, 0, 1, 0, 8'h33};
        tbl[10] = '{0, 1, 1, 0, 8'h00, 5'd0, 1, 0, 0, 0, 1, 8'h44};
        tbl[11] = '{0, 1, 1, 0, 8'h00, 5'd0, 1, 0, 0, 1, 0, 8'h44};
        tbl[12] = '{0, 0, 1, 0, 8'h00, 5'd0, 1, 0, 0, 0, 0, 8'h44};

        model_reset();
        #12;
        chk("reset empty", FIFO_Empty, 1'b1);
        chk("reset count", FIFO_Count, 5'd0);
        chk("reset dout", Data_Out, 8'h00);
        chk("reset flags", {FIFO_Full, FIFO_Overflow, FIFO_Underflow, Data_Valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rdy, tbl[i].pop, tbl[i].d, tbl[i].clr, tbl[i].bist);
            chk($sformatf("vec%0d count", i), FIFO_Count, tbl[i].cnt);
            chk($sformatf("vec%0d empty", i), FIFO_Empty, tbl[i].emp);
            chk($sformatf("vec%0d full", i), FIFO_Full, tbl[i].ful);
            chk($sformatf("vec%0d ovf", i), FIFO_Overflow, tbl[i].ovf);
            chk($sformatf("vec%0d udf", i), FIFO_Underflow, tbl[i].udf);
            if (!FWFT) begin
                chk($sformatf("vec%0d dv", i), Data_Valid, tbl[i].dv);
                chk($sformatf("vec%0d dout", i), Data_Out, tbl[i].dout);
            end
        end
        m_last = 8'h44;

        // Async reset in the middle of a push burst with underflow pending
        mstep("pre udf", 0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) mstep("burst", 1, 0, 8'h90 + 8'(i), 0, 0);
        Data_Rdy = 1'b1; Rx_Data = 8'hEE;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset empty", FIFO_Empty, 1'b1);
        chk("midreset count", FIFO_Count, 5'd0);
        chk("midreset dout", Data_Out, 8'h00);
        chk("midreset flags", {FIFO_Full, FIFO_Overflow, FIFO_Underflow, Data_Valid}, 4'b0000);
        Data_Rdy = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to 16, overflow, simultaneous push/pop at full, clear, drain
        for (int i = 0; i < 16; i++) mstep($sformatf("fill%0d", i), 1, 0, 8'(i), 0, 0);
        mstep("push full", 1, 0, 8'hAA, 0, 0);
        mstep("push+pop full", 1, 1, 8'h55, 0, 0);
        mstep("clr ovf", 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) mstep($sformatf("drain%0d", i), 0, 1, 8'h00, 0, 0);
        mstep("push+pop empty", 1, 1, 8'h77, 0, 0);
        mstep("clr udf", 0, 0, 8'h00, 1, 0);

        // Interleaved random traffic to wrap pointers
        for (int i = 0; i < 40; i++)
            mstep($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 0, 0);
        while (q.size() > 0) mstep("flush", 0, 1, 8'h00, 0, 0);

`ifdef RX_FIFO_FWFT_EN
        mstep("fwft push", 1, 0, 8'h3C, 0, 0);
        chk("fwft dout", Data_Out, 8'h3C);
        chk("fwft dv", Data_Valid, 1'b1);
`endif

        // BIST freeze with traffic applied
        mstep("bist pre0", 1, 0, 8'hA1, 0, 0);
        mstep("bist pre1", 1, 1, 8'hA2, 0, 0);
        for (int i = 0; i < 4; i++) mstep($sformatf("bist%0d", i), 1, 1, 8'hB0 + 8'(i), 1, 1);
        mstep("bist post", 0, 1, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
